mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised successor to the 32-bit loadable incrementing counter.
- Adds configurable width, arbitrary modulus, up/down direction, count enable, a terminal-count indicator and wrap event/sticky flags.
- Used as a general program/loop/timer counter in the datapath; drives any consumer of a registered count value.

Parameters:
WIDTH, 32, counter width in bits (2..32).
MODULUS, 0, count range 0..MODULUS-1; 0 means full range 2^WIDTH.
RESET_VAL, 0, value taken on reset; must be < effective modulus.

Ports:
cl  input  1  clock, rising edge.
clear  input  1  reset, asynchronous, active-low.
en  input  1  count enable, active-high.
load  input  1  synchronous parallel load, active-low.
up  input  1  direction: 1 = increment, 0 = decrement.
X  input  WIDTH  parallel load value.
ack_wrap  input  1  clears wrap_sticky, active-high.
Y  output  WIDTH  current count (registered).
tc  output  1  terminal count (combinational from Y, up, en).
wrap  output  1  one-cycle pulse, registered, following a wrap step.
wrap_sticky  output  1  latched wrap indicator.

Behaviour:
- Reset: clear low forces Y=RESET_VAL, wrap=0, wrap_sticky=0 immediately, independent of cl. Deassertion is synchronised externally.
- Priority at each rising cl edge while clear high: load (low) > en count > hold.
- Load: Y <= X. If X >= effective modulus, Y <= modulus-1 (clamp). Load never sets wrap. The en input is ignored that cycle.
- Count up: Y <= Y+1. If Y == modulus-1, Y <= 0 (wrap step).
- Count down: Y <= Y-1. If Y == 0, Y <= modulus-1 (wrap step).
- Full range (MODULUS=0): natural binary wrap; arithmetic is WIDTH-bit, carry/borrow is discarded.
- tc = en & (up ? Y==modulus-1 : Y==0). It is asserted the cycle before a wrap step.
- wrap: high for exactly the one cycle after a wrap step; 0 otherwise. It is 0 after a load.
- wrap_sticky:
  - Set by a wrap step and held until ack_wrap is sampled high.
  - Simultaneous wrap step and ack_wrap: set wins (stays 1).
- Hold: en=0, load=1 keeps Y and wrap_sticky; wrap returns to 0.
- A direction change takes effect on the same edge; there is no pipeline.
- Latency: 1 cycle from load/en/up sampling to Y.
- Reset mid-count drops all state to reset values; the count resumes from RESET_VAL on the first edge after release.

Optional Feature:
- Macro: MOD_COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - Up at modulus-1 holds modulus-1; down at 0 holds 0.
  - The wrap/wrap_sticky set source becomes the saturation event (attempted count past a limit).
  - tc behaviour is unchanged.
- Undefined: wrap-around behaviour as above. Saturation logic is absent.

Decomposition:
- Shared package counter_pkg:
  - max supported width constant (32);
  - function computing the effective modulus (MODULUS==0 -> 2^WIDTH);
  - direction constants CNT_UP=1, CNT_DOWN=0.
- Sub-module mod_incdec (combinational), parametrised by WIDTH/MODULUS:
  - inputs: value, up;
  - outputs: next value, wrap flag (limit-hit flag under saturation).
  - It supersedes the plain incrementer for this block.
- Top level holds the registers, priority mux, load clamp and flags.

Test Plan:
1. WIDTH=4, MODULUS=10, up=1, en=1 from reset -> Y 0..9 then 0. tc high at Y=9. wrap high the cycle Y=0 follows 9. wrap_sticky=1 until ack_wrap.
2. Same config, load=0, X=7, then up=0, en=1 -> Y=7,6,...,0,9. tc at Y=0. Load X=12 -> Y=9 (clamp), wrap=0.
3. WIDTH=8, MODULUS=0, Y=255, up=1 -> Y=0, wrap pulse. Then up=0 -> Y=255, wrap pulse again.
4. Wrap step and ack_wrap high on the same edge -> wrap_sticky stays 1. Next edge with ack_wrap=1 and no wrap -> 0.
5. clear pulsed low mid-cycle while counting at Y=5 -> Y=RESET_VAL (0) before the next cl edge, flags 0. Simultaneous load=0 and en=1 -> load wins.
6. With MOD_COUNTER_SATURATE_EN, MODULUS=10, counting up from 8 -> Y=8,9,9,9. wrap pulses on each attempted overshoot. Down from 1 -> 0,0.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the modulo counter slice.
//   MAX_WIDTH    - widest supported counter
//   dir_e        - count direction encoding (CNT_UP = 1, CNT_DOWN = 0)
//   eff_modulus  - effective modulus; MODULUS == 0 selects the full 2^WIDTH range.
//                  The result is 33 bits wide so that 2^32 is representable.
package counter_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } dir_e;

    function automatic logic [MAX_WIDTH:0] eff_modulus(input int unsigned width,
                                                       input int unsigned modulus);
        logic [MAX_WIDTH:0] m;
        if (modulus == 0) begin
            m = (MAX_WIDTH+1)'(1) << width;
        end else begin
            m = (MAX_WIDTH+1)'(modulus);
        end
        return m;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle of mod_counter.
//   en, load (active-low), up, X, ack_wrap : controller -> counter
//   Y, tc, wrap, wrap_sticky                : counter -> consumers
// The master modport drives the controls; the slave modport is the counter side.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             load;
    logic             up;
    logic [WIDTH-1:0] X;
    logic             ack_wrap;
    logic [WIDTH-1:0] Y;
    logic             tc;
    logic             wrap;
    logic             wrap_sticky;

    modport master (
        output en, load, up, X, ack_wrap,
        input  Y, tc, wrap, wrap_sticky
    );

    modport slave (
        input  en, load, up, X, ack_wrap,
        output Y, tc, wrap, wrap_sticky
    );
endinterface

// File: rtl/mod_incdec.sv
// mod_incdec: combinational modulo incrementer/decrementer.
//   value - current count
//   up    - 1 = increment, 0 = decrement
//   next  - following count value
//   wrap  - the step crosses a range limit (wrap step, or saturation event when
//           MOD_COUNTER_SATURATE_EN is defined)
// Build option MOD_COUNTER_SATURATE_EN: hold at the limit instead of wrapping.
module mod_incdec
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MODULUS = 0
) (
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);
    localparam logic [MAX_WIDTH:0] MODV = eff_modulus(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0]   MAXV = WIDTH'(MODV - (MAX_WIDTH+1)'(1));

    always_comb begin
        next = value;
        wrap = 1'b0;
        if (up == CNT_UP) begin
            if (value == MAXV) begin
                wrap = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                next = MAXV;
`else
                next = '0;
`endif
            end else begin
                next = value + WIDTH'(1);
            end
        end else begin
            if (value == '0) begin
                wrap = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
                next = '0;
`else
                next = MAXV;
`endif
            end else begin
                next = value - WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised loadable modulo up/down counter.
//   cl     - clock, rising edge
//   clear  - asynchronous reset, active-low
//   bus    - mod_counter_if.slave: en, load (active-low), up, X, ack_wrap in;
//            Y (registered count), tc, wrap (one-cycle pulse), wrap_sticky out
// Parameters: WIDTH (2..32), MODULUS (0 = 2^WIDTH), RESET_VAL (< modulus).
// Build option MOD_COUNTER_SATURATE_EN: counting saturates at the limits and
// the wrap flags report attempted overshoot instead of wrap-around.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MODULUS   = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic          cl,
    input  logic          clear,
    mod_counter_if.slave  bus
);
    localparam logic [MAX_WIDTH:0] MODV = eff_modulus(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0]   MAXV = WIDTH'(MODV - (MAX_WIDTH+1)'(1));
    localparam logic [WIDTH-1:0]   RSTV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] y_q;
    logic             wrap_q;
    logic             sticky_q;
    logic [WIDTH-1:0] step_val;
    logic             step_lim;
    logic             wrap_step;
    logic [WIDTH-1:0] load_val;

    mod_incdec #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_incdec (
        .value (y_q),
        .up    (bus.up),
        .next  (step_val),
        .wrap  (step_lim)
    );

    always_comb begin
        // Clamp out-of-range loads to the top of the range.
        load_val = bus.X;
        if ((MAX_WIDTH+1)'(bus.X) >= MODV) begin
            load_val = MAXV;
        end
        // A wrap step needs an actual count cycle; a load masks it.
        wrap_step = bus.load & bus.en & step_lim;
    end

    always_ff @(posedge cl or negedge clear) begin
        if (!clear) begin
            y_q      <= RSTV;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (!bus.load) begin
                y_q <= load_val;
            end else if (bus.en) begin
                y_q <= step_val;
            end
            wrap_q   <= wrap_step;
            // Set has priority over acknowledge.
            sticky_q <= wrap_step | (sticky_q & ~bus.ack_wrap);
        end
    end

    assign bus.Y           = y_q;
    assign bus.wrap        = wrap_q;
    assign bus.wrap_sticky = sticky_q;
    assign bus.tc          = bus.en & ((bus.up == CNT_UP) ? (y_q == MAXV) : (y_q == '0));
endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    typedef struct {
        logic [7:0] y;
        logic       w;
        logic       s;
        logic       t;
    } exp_t;

    logic cl;
    logic clear;
    int   total;
    int   bad;
    exp_t qa[$];
    exp_t qb[$];

    mod_counter_if #(.WIDTH(4)) bus_a ();
    mod_counter_if #(.WIDTH(8)) bus_b ();

    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
        .cl    (cl),
        .clear (clear),
        .bus   (bus_a.slave)
    );

    mod_counter #(.WIDTH(8), .MODULUS(0), .RESET_VAL(0)) dut_b (
        .cl    (cl),
        .clear (clear),
        .bus   (bus_b.slave)
    );

    initial cl = 1'b0;
    always #5 cl = ~cl;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: the state is presented every cycle; compare mid-cycle.
    always @(negedge cl) begin
        if (qa.size() > 0) begin
            exp_t e;
            e = qa.pop_front();
            check("a_Y", {4'h0, bus_a.Y}, e.y);
            check("a_wrap", {7'h0, bus_a.wrap}, {7'h0, e.w});
            check("a_sticky", {7'h0, bus_a.wrap_sticky}, {7'h0, e.s});
            check("a_tc", {7'h0, bus_a.tc}, {7'h0, e.t});
        end
        if (qb.size() > 0) begin
            exp_t e;
            e = qb.pop_front();
            check("b_Y", bus_b.Y, e.y);
            check("b_wrap", {7'h0, bus_b.wrap}, {7'h0, e.w});
            check("b_sticky", {7'h0, bus_b.wrap_sticky}, {7'h0, e.s});
            check("b_tc", {7'h0, bus_b.tc}, {7'h0, e.t});
        end
    end

    // Apply inputs for the coming edge and queue the state expected before it.
    task automatic stepa(input logic e, input logic l, input logic u, input logic [3:0] x,
                         input logic a, input logic [3:0] ey, input logic ew,
                         input logic es, input logic et);
        exp_t ex;
        bus_a.en = e; bus_a.load = l; bus_a.up = u; bus_a.X = x; bus_a.ack_wrap = a;
        ex.y = {4'h0, ey}; ex.w = ew; ex.s = es; ex.t = et;
        qa.push_back(ex);
        @(posedge cl);
        #1;
    endtask

    task automatic stepb(input logic e, input logic l, input logic u, input logic [7:0] x,
                         input logic a, input logic [7:0] ey, input logic ew,
                         input logic es, input logic et);
        exp_t ex;
        bus_b.en = e; bus_b.load = l; bus_b.up = u; bus_b.X = x; bus_b.ack_wrap = a;
        ex.y = ey; ex.w = ew; ex.s = es; ex.t = et;
        qb.push_back(ex);
        @(posedge cl);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b0;
        bus_a.en = 1'b0; bus_a.load = 1'b1; bus_a.up = 1'b1; bus_a.X = '0; bus_a.ack_wrap = 1'b0;
        bus_b.en = 1'b0; bus_b.load = 1'b1; bus_b.up = 1'b1; bus_b.X = '0; bus_b.ack_wrap = 1'b0;
        @(posedge cl);
        #1;
        // reset state
        stepa(0, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
        clear = 1'b1;

`ifndef MOD_COUNTER_SATURATE_EN
        // count up 0..9 then wrap to 0
        for (int i = 0; i < 10; i++) begin
            stepa(1, 1, 1, 4'd0, 0, 4'(i), 0, 0, (i == 9));
        end
        stepa(1, 1, 1, 4'd0, 0, 4'd0, 1, 1, 0);
        stepa(0, 1, 1, 4'd0, 1, 4'd1, 0, 1, 0);
        stepa(0, 1, 1, 4'd0, 0, 4'd1, 0, 0, 0);
        // load 7 with en high (load wins), then count down through 0 to 9
        stepa(1, 0, 0, 4'd7, 0, 4'd1, 0, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            stepa(1, 1, 0, 4'd0, 0, 4'(i), 0, 0, (i == 0));
        end
        // load 12 clamps to 9 and clears the wrap pulse
        stepa(1, 0, 0, 4'd12, 0, 4'd9, 1, 1, 0);
        stepa(0, 1, 0, 4'd0, 0, 4'd9, 0, 1, 0);
        stepa(0, 1, 1, 4'd0, 1, 4'd9, 0, 1, 0);
        // wrap step coincident with ack: set wins; ack alone clears next
        stepa(1, 1, 1, 4'd0, 1, 4'd9, 0, 0, 1);
        stepa(0, 1, 1, 4'd0, 1, 4'd0, 1, 1, 0);
        stepa(0, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
`else
        // saturating: up from 8 sticks at 9, down from 1 sticks at 0
        stepa(0, 0, 1, 4'd8, 0, 4'd0, 0, 0, 0);
        stepa(1, 1, 1, 4'd0, 0, 4'd8, 0, 0, 0);
        stepa(1, 1, 1, 4'd0, 0, 4'd9, 0, 0, 1);
        stepa(1, 1, 1, 4'd0, 0, 4'd9, 1, 1, 1);
        stepa(0, 0, 0, 4'd1, 1, 4'd9, 1, 1, 0);
        stepa(1, 1, 0, 4'd0, 0, 4'd1, 0, 0, 0);
        stepa(1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 1);
        stepa(0, 1, 0, 4'd0, 1, 4'd0, 1, 1, 0);
        stepa(0, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0);
`endif

        // count to 5 then clear asynchronously mid-cycle
        for (int i = 0; i < 5; i++) begin
            stepa(1, 1, 1, 4'd0, 0, 4'(i), 0, 0, 0);
        end
        bus_a.en = 1'b1; bus_a.load = 1'b1; bus_a.up = 1'b1; bus_a.ack_wrap = 1'b0;
        #1;
        clear = 1'b0;
        begin
            exp_t ex;
            ex.y = 8'd0; ex.w = 1'b0; ex.s = 1'b0; ex.t = 1'b0;
            qa.push_back(ex);
        end
        @(negedge cl);
        #1;
        clear = 1'b1;
        @(posedge cl);
        #1;
        // count resumed from 0; now load and en together
        stepa(1, 0, 1, 4'd3, 0, 4'd1, 0, 0, 0);
        stepa(0, 1, 1, 4'd0, 0, 4'd3, 0, 0, 0);

`ifndef MOD_COUNTER_SATURATE_EN
        // full-range 8-bit: 255 -> 0 up, 0 -> 255 down
        stepb(0, 0, 1, 8'd255, 0, 8'd0, 0, 0, 0);
        stepb(1, 1, 1, 8'd0, 0, 8'd255, 0, 0, 1);
        stepb(1, 1, 0, 8'd0, 0, 8'd0, 1, 1, 1);
        stepb(0, 1, 0, 8'd0, 0, 8'd255, 1, 1, 0);
        stepb(0, 1, 0, 8'd0, 1, 8'd255, 0, 1, 0);
        stepb(0, 1, 1, 8'd0, 0, 8'd255, 0, 0, 0);
`else
        stepb(0, 0, 1, 8'd255, 0, 8'd0, 0, 0, 0);
        stepb(1, 1, 1, 8'd0, 0, 8'd255, 0, 0, 1);
        stepb(1, 1, 0, 8'd0, 0, 8'd255, 1, 1, 0);
        stepb(0, 1, 0, 8'd0, 0, 8'd254, 0, 1, 0);
`endif

        @(posedge cl);
        #1;
        total++;
        if ((qa.size() + qb.size()) != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected 0", qa.size() + qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
